banked_mem_responder: RTL and testbench

- Responder end of the cache-to-memory interface: a four-bank, word-interleaved, 16-bit data memory that accepts one `rd`/`wr` per cycle.
- Each access occupies its bank for a fixed number of cycles; a new access to a busy bank is refused with `stall`.
- Read data returns a fixed two cycles after acceptance.
- Sits directly under the cache controller, in place of the behavioural memory, and exposes the same port set so it drops into the existing instantiation.

---
 rtl/banked_mem_responder.sv | 103 ++++++++++
 tb/tb_banked_mem_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/banked_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : banked_mem_responder
// Brief    : Four-bank, word-interleaved 16-bit memory responder with per-bank
//            busy windows, two-cycle read latency and a protocol error pulse.
//            Optional BANKED_MEM_ALIGN_CHECK_EN: odd byte addresses raise err.
// Revision : 1.0 - initial release
// ============================================================================
module banked_mem_responder #(
  parameter int BUSY_CYCLES    = 3,
  parameter int WORDS_PER_BANK = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        createdump,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        wr,
  input  logic        rd,
  output logic [15:0] data_out,
  output logic        stall,
  output logic [3:0]  busy,
  output logic        err
);

  localparam int         ROW_W  = $clog2(WORDS_PER_BANK);
  localparam int         IDX_W  = ROW_W + 2;
  localparam int         DEPTH  = 4 * WORDS_PER_BANK;
  localparam logic [2:0] C_BUSY = 3'(BUSY_CYCLES);

  logic [15:0]          r_mem [0:DEPTH-1];
  logic [3:0][2:0]      r_cnt;
  logic                 r_s1_vld;
  logic [IDX_W-1:0]     r_s1_idx;
  logic [15:0]          r_data_out;
  logic                 r_err;

  logic                 w_req;
  logic [1:0]           w_bank;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_err;
  logic                 w_stall;
  logic                 w_accept;

  assign w_req  = rd | wr;
  assign w_bank = addr[2:1];
  assign w_idx  = {addr[2:1], addr[ROW_W+2:3]};

`ifdef BANKED_MEM_ALIGN_CHECK_EN
  assign w_err = (rd & wr) | (w_req & addr[0]);
`else
  assign w_err = rd & wr;
`endif

  assign w_stall  = rst & w_req & busy[w_bank];
  assign w_accept = rst & w_req & ~w_stall & ~w_err;

  // createdump is serviced by the simulation environment; no architectural effect
  logic w_unused;
  assign w_unused = &{1'b0, createdump, addr[0]};

  always_ff @(posedge clk) begin
    if (w_accept && wr) begin
      r_mem[w_idx] <= data_in;
    end
  end

  // Stage 1 holds the accepted read address; stage 2 is the data_out register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_vld   <= 1'b0;
      r_s1_idx   <= '0;
      r_data_out <= 16'h0000;
      r_err      <= 1'b0;
    end else begin
      r_s1_vld   <= w_accept & rd;
      r_s1_idx   <= w_idx;
      r_data_out <= r_s1_vld ? r_mem[r_s1_idx] : 16'h0000;
      r_err      <= w_err;
    end
  end

  generate
    for (genvar n = 0; n < 4; n++) begin : g_bank
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_cnt[n] <= 3'd0;
        end else if (w_accept && (w_bank == 2'(n))) begin
          r_cnt[n] <= C_BUSY;
        end else if (r_cnt[n] != 3'd0) begin
          r_cnt[n] <= r_cnt[n] - 3'd1;
        end
      end
      assign busy[n] = |r_cnt[n];
    end
  endgenerate

  assign stall    = w_stall;
  assign data_out = r_data_out;
  assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_banked_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_banked_mem_responder
// Brief    : Scoreboard bench for banked_mem_responder; directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_banked_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        createdump;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  banked_mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .createdump (createdump),
    .addr       (addr),
    .data_in    (data_in),
    .wr         (wr),
    .rd         (rd),
    .data_out   (data_out),
    .stall      (stall),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: data_out must match the scoreboard head when due, else be zero
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk("rdata", data_out, e.val);
      end else begin
        chk("idle_data", data_out, 16'h0000);
      end
    end
  end

  task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    rd = r; wr = w; addr = a; data_in = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic push_rd(input logic [15:0] v);
    exp_t e;
    e.due = cyc + 2;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic write_word(input logic [15:0] a, input logic [15:0] d);
    drive(1'b0, 1'b1, a, d);
    step();
    idle();
    repeat (3) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; createdump = 1'b0;
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    step(); step();
    mon_en = 1'b1;
    at_neg();
    chk("rst_stall", {15'd0, stall}, 16'd0);
    chk("rst_busy", {12'd0, busy}, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    step();
    rst = 1'b1;
    idle();
    step();

    // Preload known words
    write_word(16'h0000, 16'h1111);
    write_word(16'h0008, 16'h2222);
    write_word(16'h0020, 16'h5A5A);
    write_word(16'h0010, 16'h0001);
    write_word(16'h0012, 16'h0002);
    write_word(16'h0014, 16'h0003);
    write_word(16'h0016, 16'h0004);

    // Write then read (bank 2)
    drive(1'b0, 1'b1, 16'h0104, 16'hBEEF);
    at_neg(); chk("wr_stall", {15'd0, stall}, 16'd0);
    step(); idle();
    at_neg(); chk("wr_busy", {12'd0, busy}, 16'b0100);
    step(); step(); step();
    drive(1'b1, 1'b0, 16'h0104, 16'h0000);
    at_neg(); chk("rd_stall", {15'd0, stall}, 16'd0);
    push_rd(16'hBEEF);
    step(); idle();
    repeat (4) step();

    // Bank conflict on bank 0
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    at_neg(); chk("conf_first_stall", {15'd0, stall}, 16'd0);
    push_rd(16'h1111);
    step();
    drive(1'b1, 1'b0, 16'h0008, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("conf_stall", {15'd0, stall}, 16'd1);
      chk("conf_busy", {12'd0, busy}, 16'b0001);
      step();
    end
    at_neg(); chk("conf_accept", {15'd0, stall}, 16'd0);
    push_rd(16'h2222);
    step(); idle();
    repeat (4) step();

    // Interleave across all four banks
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 16'h0010 + 16'(2 * i), 16'h0000);
      at_neg(); chk("il_stall", {15'd0, stall}, 16'd0);
      push_rd(16'(i + 1));
      step();
    end
    idle();
    at_neg(); chk("il_busy", {12'd0, busy}, 16'b1110);
    repeat (4) step();

    // Protocol error: rd & wr together
    drive(1'b1, 1'b1, 16'h0020, 16'h1234);
    at_neg(); chk("err_stall", {15'd0, stall}, 16'd0);
    step(); idle();
    at_neg();
    chk("err_pulse", {15'd0, err}, 16'd1);
    chk("err_busy", {12'd0, busy}, 16'd0);
    step();
    at_neg(); chk("err_clear", {15'd0, err}, 16'd0);
    drive(1'b1, 1'b0, 16'h0020, 16'h0000);
    push_rd(16'h5A5A);
    step(); idle();
    repeat (4) step();

    // Odd byte address
    drive(1'b1, 1'b0, 16'h0021, 16'h0000);
`ifdef BANKED_MEM_ALIGN_CHECK_EN
    step(); idle();
    at_neg();
    chk("align_err", {15'd0, err}, 16'd1);
    chk("align_busy", {12'd0, busy}, 16'd0);
`else
    push_rd(16'h5A5A);
    step(); idle();
    at_neg(); chk("align_noerr", {15'd0, err}, 16'd0);
`endif
    repeat (4) step();

    // Reset mid-read: the in-flight read must vanish
    drive(1'b1, 1'b0, 16'h0104, 16'h0000);
    step(); idle();
    rst = 1'b0;
    step();
    at_neg(); chk("mid_rst_busy", {12'd0, busy}, 16'd0);
    rst = 1'b1;
    step();
    at_neg(); chk("post_rst_busy", {12'd0, busy}, 16'd0);
    repeat (3) step();

    chk("sb_drained", 16'(sb.size()), 16'd0);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
